ram_burst_master: RTL
=====================

# ram_burst_master

Initiator-side burst engine for the team's single-port synchronous RAM. Accepts a command (direction, start address, length), then streams write beats into the RAM or read beats out of it over valid/ready channels, generating sequential addresses. Sits between a DMA/stream client and one RAM instance, driving that RAM's WE/RE/addr/WD port and consuming its registered RD.

## Interface
- WIDTH, 8: data width; must match the RAM.
- ADDR, 8: address width; must match the RAM.
- LEN_W, 8: burst length field width; a burst is cmd_len+1 beats, so up to 2^LEN_W beats.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR  start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid / wr_ready  in / out  1  write data handshake.
- wr_data  in  WIDTH  write beat.
- rd_valid / rd_ready  out / in  1  read data handshake.
- rd_data  out  WIDTH  read beat.
- ram_we, ram_re  out  1  RAM strobes; never both 1.
- ram_addr  out  ADDR  RAM address.
- ram_wd  out  WIDTH  RAM write data (= wr_data).
- ram_rd  in  WIDTH  RAM read data, valid the cycle after ram_re.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, WRITE, READ, DRAIN. cmd_ready = (state == IDLE).
- IDLE: on cmd_valid&cmd_ready, latch addr, beat counter = cmd_len; go to WRITE or READ.
- WRITE: wr_ready = 1; ram_we = wr_valid; ram_addr = current addr. Each accepted beat increments addr and decrements the counter. Last beat -> IDLE, done = 1 next cycle.
- READ: ram_re issued when skid credit allows: occupancy + inflight - pop < 2 (inflight = ram_re last cycle, pop = rd_valid&rd_ready). Each issue increments addr and decrements the counter. Last issue -> DRAIN.
- DRAIN: no new issues; when the last beat is handshaked on rd -> IDLE, done = 1 next cycle.
- ram_rd pushed into a 2-entry skid FIFO the cycle after ram_re; rd_valid/rd_data come from its head.
- Address wraps modulo 2^ADDR (unless the boundary check below is compiled in).
- wr_ready = 0 and ram_we = 0 outside WRITE; ram_re = 0 outside READ.

## Timing
- Reset values: state IDLE (cmd_ready 1), busy 0, done 0, ram_we 0, ram_re 0, ram_addr 0, rd_valid 0, rd_data 0, skid empty, inflight 0.
- Command accepted cycle t -> WRITE/READ at t+1.
- Write, wr_valid held: beats written t+1..t+N+1 (N = cmd_len); IDLE and done at t+N+2.
- Read: first ram_re at t+1, first rd_valid at t+3; one beat per cycle with rd_ready held high.
- rd_ready low: at most 2 beats buffered; issue stalls and resumes without loss or duplication.
- cmd_len = 0: single beat. Counter is LEN_W bits; cmd_len = all-ones gives 2^LEN_W beats.
- Reset mid-burst: burst aborted immediately, skid and inflight cleared, no done.

## Configuration
- RAM_BURST_BOUNDARY_CHK_EN defined: adds output cmd_err (1 bit, reset 0). A command with cmd_addr + cmd_len > 2^ADDR - 1 is consumed (cmd_ready 1), not executed; cmd_err pulses one cycle after acceptance; state stays IDLE; no RAM access, no done.
- Undefined: no cmd_err port; addresses wrap to 0.

## Structure
- Package ram_burst_pkg: state enum (IDLE, WRITE, READ, DRAIN), SKID_DEPTH = 2.
- Sub-module ram_rd_skid: 2-entry FIFO with push/pop, count output, data/valid head.

## Test plan
- Write addr 0x10, len 3, data 0xA1..0xA4, wr_valid held -> ram_we at t+1..t+4, ram_addr 0x10..0x13, done at t+5.
- Read back the same burst, rd_ready held 1 -> rd_data 0xA1..0xA4 on consecutive cycles from t+3, done after last beat.
- Read len 7 with rd_ready toggled 1/0 -> 8 beats in address order, never more than 2 buffered, no RE/WE overlap.
- Write addr 0xFE, len 3 (check macro off) -> ram_addr 0xFE, 0xFF, 0x00, 0x01; with macro on -> cmd_err pulse, no ram_we, no done.
- rstn low during read beat 2 of 5 -> all outputs at reset values; new command then accepted normally.
- cmd_len 0 write then read -> single beat each, done pulse each.

Source files
------------

// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master and its read skid buffer.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO that catches registered RAM read data so the read channel
// can stall without losing beats already in flight.
module ram_rd_skid
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data
);

  logic [WIDTH-1:0]      r_mem [SKID_DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != SKID_CNT_W'(SKID_DEPTH)) || w_pop);

  // Pointer and occupancy bookkeeping; cleared by reset so the buffer starts empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + SKID_CNT_W'(1);
        2'b01:   r_count <= r_count - SKID_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

endmodule

// File: rtl/ram_burst_master.sv
// Burst engine for a single-port synchronous RAM: accepts a command, then
// streams write beats into the RAM or read beats out through a skid buffer.
// Optional feature macro: RAM_BURST_BOUNDARY_CHK_EN adds cmd_err and rejects
// bursts that would run past the top of the address space.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             ram_we,
  output logic             ram_re,
  output logic [ADDR-1:0]  ram_addr,
  output logic [WIDTH-1:0] ram_wd,
  input  logic [WIDTH-1:0] ram_rd,
  output logic             busy,
`ifdef RAM_BURST_BOUNDARY_CHK_EN
  output logic             cmd_err,
`endif
  output logic             done
);

  localparam int OCC_W = SKID_CNT_W + 1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR-1:0]       r_addr;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_re_p1;
  logic                  r_done;
  logic                  w_cmd_acc;
  logic                  w_start;
  logic                  w_oob;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_burst_end;
  logic [SKID_CNT_W-1:0] w_skid_cnt;
  logic [OCC_W-1:0]      w_occ;
  logic [OCC_W-1:0]      w_lim;

`ifdef RAM_BURST_BOUNDARY_CHK_EN
  localparam int SUM_W = ((ADDR > LEN_W) ? ADDR : LEN_W) + 1;
  logic [SUM_W-1:0] w_end;
  logic             r_err;

  // Any bit above the address field means the burst would pass the top address.
  assign w_end = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign w_oob = |(w_end >> ADDR);
`else
  assign w_oob = 1'b0;
`endif

  assign w_cmd_acc = cmd_valid && (r_state == IDLE);
  assign w_start   = w_cmd_acc && !w_oob;
  assign w_pop     = rd_valid && rd_ready;

  // Issue credit: beats buffered plus the one in flight, less the one leaving now.
  assign w_occ    = {1'b0, w_skid_cnt} + OCC_W'(r_re_p1);
  assign w_lim    = OCC_W'(SKID_DEPTH) + OCC_W'(w_pop);
  assign w_credit = (w_occ < w_lim);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and RAM/channel strobes.
  always_comb begin
    w_next      = r_state;
    wr_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    w_burst_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        if (wr_valid && (r_cnt == '0)) begin
          w_next      = IDLE;
          w_burst_end = 1'b1;
        end
      end
      READ: begin
        ram_re = w_credit;
        if (w_credit && (r_cnt == '0)) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_pop && (w_skid_cnt == SKID_CNT_W'(1)) && !r_re_p1) begin
          w_next      = IDLE;
          w_burst_end = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: address/count walk, in-flight read marker, done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_re_p1 <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_re_p1 <= ram_re;
      r_done  <= w_burst_end;
      if (w_start) begin
        r_addr <= cmd_addr;
        r_cnt  <= cmd_len;
      end else if (ram_we || ram_re) begin
        r_addr <= r_addr + ADDR'(1);
        r_cnt  <= r_cnt - LEN_W'(1);
      end
    end
  end

`ifdef RAM_BURST_BOUNDARY_CHK_EN
  // Error pulse one cycle after an out-of-range command is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err <= 1'b0;
    else       r_err <= w_cmd_acc && w_oob;
  end

  assign cmd_err = r_err;
`endif

  // Stage p1 -> p2: registered RAM data lands in the skid buffer.
  ram_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (r_re_p1),
    .i_data  (ram_rd),
    .i_pop   (w_pop),
    .o_count (w_skid_cnt),
    .o_valid (rd_valid),
    .o_data  (rd_data)
  );

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ram_addr  = r_addr;
  assign ram_wd    = wr_data;

endmodule
